// File: rtl/mc_core.sv
// Multi-cycle parametrised core: 9-bit instructions, 8 registers, Z/C flags, writable jump LUT.
// Latency: 2 cycles per ALU/branch instruction (FETCH+EXEC), 3 + ack wait cycles per LD/ST.
// Backpressure: dmem_req is held with stable addr/we/wdata until dmem_ack; HALT waits for Start.
module mc_core #(
   parameter int DATA_W   = 8,
   parameter int PC_W     = 12,
   parameter int JL_DEPTH = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   output logic [PC_W-1:0]   imem_addr,
   input  logic [8:0]        imem_data,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ack,
   input  logic              jl_we,
   input  logic [2:0]        jl_idx,
   input  logic [PC_W-1:0]   jl_dat,
   output logic              Done,
   output logic [1:0]        flags
);

   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_SHF = 3'b011;
   localparam logic [2:0] OP_LDI = 3'b100;
   localparam logic [2:0] OP_LD  = 3'b101;
   localparam logic [2:0] OP_ST  = 3'b110;
   localparam logic [2:0] OP_BR  = 3'b111;

   state_t            state;
   logic [PC_W-1:0]   pc;
   logic [8:0]        ir;
   logic [DATA_W-1:0] rf [8];
   logic [PC_W-1:0]   lut [JL_DEPTH];
   logic              c_flag;
   logic              z_flag;

   logic [2:0]        op;
   logic [2:0]        ra_i;
   logic [2:0]        rb_i;
   logic [DATA_W-1:0] a_val;
   logic [DATA_W-1:0] b_val;
   logic [DATA_W:0]   sum;
   logic [DATA_W-1:0] alu_res;
   logic              alu_c;
   logic              alu_wr;
   logic              br_take;
   logic [PC_W-1:0]   pc_inc;

   assign op        = ir[8:6];
   assign ra_i      = ir[5:3];
   assign rb_i      = ir[2:0];
   assign a_val     = rf[ra_i];
   assign b_val     = rf[rb_i];
   assign pc_inc    = pc + {{(PC_W-1){1'b0}}, 1'b1};
   assign imem_addr = pc;
   assign flags     = {c_flag, z_flag};

   // ALU result, carry and branch decision for the instruction held in IR
   always_comb begin
      sum     = '0;
      alu_res = a_val;
      alu_c   = c_flag;
      alu_wr  = 1'b0;
      br_take = 1'b0;
      case (op)
         OP_ADD: begin
            sum     = {1'b0, a_val} + {1'b0, b_val};
            alu_res = sum[DATA_W-1:0];
            alu_c   = sum[DATA_W];
            alu_wr  = 1'b1;
         end
         OP_SUB: begin
            // top bit of the widened difference is the borrow
            sum     = {1'b0, a_val} - {1'b0, b_val};
            alu_res = sum[DATA_W-1:0];
            alu_c   = sum[DATA_W];
            alu_wr  = 1'b1;
         end
         OP_AND: begin
            alu_res = a_val & b_val;
            alu_wr  = 1'b1;
         end
         OP_SHF: begin
            if (rb_i[0]) begin
               alu_res = {1'b0, a_val[DATA_W-1:1]};
               alu_c   = a_val[0];
            end else begin
               alu_res = {a_val[DATA_W-2:0], 1'b0};
               alu_c   = a_val[DATA_W-1];
            end
            alu_wr = 1'b1;
         end
         OP_LDI: begin
            alu_res = {{(DATA_W-3){1'b0}}, rb_i};
            alu_wr  = 1'b1;
         end
         OP_BR: begin
            case (rb_i)
               3'd0:    br_take = 1'b1;
               3'd1:    br_take = z_flag;
               3'd2:    br_take = c_flag;
               default: br_take = 1'b0;
            endcase
         end
         default: ;
      endcase
   end

   // Jump LUT: writable in every state; a same-cycle BR sees the previous entry
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < JL_DEPTH; i++) lut[i] <= '0;
      end else if (jl_we) begin
         lut[jl_idx] <= jl_dat;
      end
   end

   // Sequencer: FETCH/EXEC/MEM/HALT with register file, flags and memory handshake
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state      <= S_FETCH;
         pc         <= '0;
         ir         <= '0;
         c_flag     <= 1'b0;
         z_flag     <= 1'b0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         Done       <= 1'b0;
         for (int i = 0; i < 8; i++) rf[i] <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               ir    <= imem_data;
               state <= S_EXEC;
            end
            S_EXEC: begin
               case (op)
                  OP_LD, OP_ST: begin
                     dmem_req   <= 1'b1;
                     dmem_we    <= (op == OP_ST);
                     dmem_addr  <= b_val;
                     dmem_wdata <= a_val;
                     state      <= S_MEM;
                  end
                  OP_BR: begin
                     if (rb_i == 3'd7) begin
                        Done  <= 1'b1;
                        state <= S_HALT;
                     end else begin
                        pc    <= br_take ? lut[ra_i] : pc_inc;
                        state <= S_FETCH;
                     end
                  end
                  default: begin
                     if (alu_wr) begin
                        rf[ra_i] <= alu_res;
                        c_flag   <= alu_c;
                        z_flag   <= (alu_res == '0);
                     end
                     pc    <= pc_inc;
                     state <= S_FETCH;
                  end
               endcase
            end
            S_MEM: begin
               if (dmem_ack) begin
                  if (!dmem_we) begin
                     rf[ra_i] <= dmem_rdata;
                     z_flag   <= (dmem_rdata == '0);
                  end
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  pc       <= pc_inc;
                  state    <= S_FETCH;
               end
            end
            S_HALT: begin
               if (Start) begin
                  pc    <= '0;
                  Done  <= 1'b0;
                  state <= S_FETCH;
               end
            end
            default: state <= S_FETCH;
         endcase
      end
   end

endmodule
